arbiter_matrix_locked: RTL and testbench
========================================

# arbiter_matrix_locked

Per-output matrix switch arbiter for the NoC router, generalising the per-output matrix arbiter with separate input and output counts, downstream-ready gating and wormhole packet locking. Each output holds its grant to one input from the granted head flit until that input's tail flit is granted. Priority rotates per packet, not per flit. Sits between route computation / input buffers and the crossbar select logic.

## Interface
- IN_PORTS, 5, number of requesting input ports
- OUT_PORTS, 5, number of output ports, each with its own priority matrix
- OUT_PORT_BITS, 3, width of one requested-output field; must satisfy 2^OUT_PORT_BITS >= OUT_PORTS
- IN_PORT_BITS, 3, width of owner index; must satisfy 2^IN_PORT_BITS >= IN_PORTS

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- ON  input  1  arbiter enable; 0 = no grants, all state held
- requests  input  IN_PORTS  request bit per input
- req_ports  input  IN_PORTS*OUT_PORT_BITS  requested output per input; field j = bits [(j+1)*OUT_PORT_BITS-1 -: OUT_PORT_BITS]
- tails  input  IN_PORTS  1 = requesting flit is a tail or single-flit packet
- out_ready  input  OUT_PORTS  1 = output can accept a flit this cycle (credit available)
- grants  output  IN_PORTS  one-hot per output; combinational from inputs and state
- locked  output  OUT_PORTS  registered; output is mid-packet
- owner  output  OUT_PORTS*IN_PORT_BITS  registered; input owning each locked output, 0 when unlocked
- port_err  output  IN_PORTS  combinational; requests[j]=1 with req_ports field j >= OUT_PORTS

## Operation
- State per output o: priority matrix pri[o][i][k] (i != k; diagonal unused, reads 0), locked[o], owner[o].
- pri[o][i][k]=1 means input i beats input k at output o. Invariant: pri[o][i][k] = ~pri[o][k][i].
- Reset: pri[o][i][k]=1 iff i>k (highest index wins first); locked=0, owner=0.
- Valid request j→o: requests[j]=1, field j = o < OUT_PORTS. Invalid fields: request ignored, port_err[j]=1, no state change.
- Unlocked output o, out_ready[o]=1, ON=1: grant input j with valid request to o not beaten by any other valid requester to o.
- Locked output o: only owner[o] may be granted, when it requests o and out_ready[o]=1; all other requesters to o are blocked.
- out_ready[o]=0: no grant for o; matrix and lock of o unchanged.
- At most one grant per output; each input requests one output, so grants never exceed one per input.
- Clocked update at rising edge when ON=1, for each output o granted to j:
  - tails[j]=0 and unlocked: locked[o]←1, owner[o]←j; matrix unchanged.
  - tails[j]=0 and locked: no change.
  - tails[j]=1: locked[o]←0, owner[o]←0; pri[o][j][k]←0 and pri[o][k][j]←1 for all k≠j (j becomes lowest).
- Owner deasserting its request while locked: lock held, output idles; no timeout.
- ON=0: grants=0, no state update; port_err still computed.

## Timing
- Grant latency zero: grants valid same cycle as requests/out_ready (combinational path through matrix and lock state).
- locked/owner/matrix change only at the rising edge following the granting cycle; new priority affects grants from the next cycle.
- Reset asynchronous: locked=0, owner=0, matrix at reset pattern, grants=0 while reset=1 and from the first cycle after release, before new requests are evaluated.
- Reset mid-packet drops all locks; upstream is responsible for flushing partial packets.
- Simultaneous tail grants on different outputs update independent matrices in the same edge.

## Test plan
- After reset, inputs 0,2,4 request output 1 (single-flit, tails=1), out_ready=all 1: grants cycle 0b10000, 0b00100, 0b00001, then 0b10000 again.
- Input 1 head to output 3 (tails=0), input 4 also requests 3: grant 0b00010 (assuming input 1 has priority after warm-up rotation), locked[3]=1, owner[3]=1 next cycle; input 4 blocked for 3 body flits until input 1 tail granted, then locked[3]=0 and input 4 granted next cycle.
- out_ready[2]=0 with input 0 requesting 2 for 4 cycles: grants=0, matrix unchanged; ready rises, grant 0b00001 same cycle.
- Input 3 req_ports=6 (OUT_PORTS=5): port_err=0b01000, grants=0, no state change.
- ON=0 with valid requests: grants=0, locked/owner frozen; ON=1 resumes identical decisions.
- Assert reset while output 0 locked to input 2: locked=0, owner=0 immediately; after release, reset priority (highest index wins) restored.

Source files
------------

// File: rtl/arbiter_matrix_locked.sv
// Per-output matrix arbiter with wormhole locking and ready gating.
// Each output keeps its own priority matrix; rotation happens on tail grants.
module arbiter_matrix_locked #(
  parameter int IN_PORTS      = 5,
  parameter int OUT_PORTS     = 5,
  parameter int OUT_PORT_BITS = 3,
  parameter int IN_PORT_BITS  = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ON,
  input  logic [IN_PORTS-1:0]               requests,
  input  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports,
  input  logic [IN_PORTS-1:0]               tails,
  input  logic [OUT_PORTS-1:0]              out_ready,
  output logic [IN_PORTS-1:0]               grants,
  output logic [OUT_PORTS-1:0]              locked,
  output logic [OUT_PORTS*IN_PORT_BITS-1:0] owner,
  output logic [IN_PORTS-1:0]               port_err
);

  logic                     r_pri [OUT_PORTS][IN_PORTS][IN_PORTS];
  logic [OUT_PORTS-1:0]     r_locked;
  logic [IN_PORT_BITS-1:0]  r_owner [OUT_PORTS];

  logic [OUT_PORT_BITS-1:0] w_field [IN_PORTS];
  logic [IN_PORTS-1:0]      w_cand  [OUT_PORTS];
  logic [IN_PORTS-1:0]      w_gnt   [OUT_PORTS];

  always_comb begin
    port_err = '0;
    grants   = '0;
    for (int j = 0; j < IN_PORTS; j++) begin
      w_field[j]  = req_ports[j*OUT_PORT_BITS +: OUT_PORT_BITS];
      port_err[j] = requests[j] && (int'(w_field[j]) >= OUT_PORTS);
    end
    // A locked output only considers its owner as a candidate
    for (int o = 0; o < OUT_PORTS; o++) begin
      w_cand[o] = '0;
      for (int j = 0; j < IN_PORTS; j++) begin
        w_cand[o][j] = !reset && ON && out_ready[o] && requests[j]
                    && (int'(w_field[j]) == o)
                    && (!r_locked[o]
                        || (r_owner[o] == IN_PORT_BITS'(j)));
      end
    end
    for (int o = 0; o < OUT_PORTS; o++) begin
      w_gnt[o] = w_cand[o];
      for (int j = 0; j < IN_PORTS; j++) begin
        for (int k = 0; k < IN_PORTS; k++) begin
          if (k != j && w_cand[o][k] && r_pri[o][k][j])
            w_gnt[o][j] = 1'b0;
        end
      end
      grants = grants | w_gnt[o];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < OUT_PORTS; o++) begin
        r_locked[o] <= 1'b0;
        r_owner[o]  <= '0;
        for (int i = 0; i < IN_PORTS; i++)
          for (int k = 0; k < IN_PORTS; k++)
            r_pri[o][i][k] <= (i > k);
      end
    end else if (ON) begin
      for (int o = 0; o < OUT_PORTS; o++) begin
        for (int j = 0; j < IN_PORTS; j++) begin
          if (w_gnt[o][j]) begin
            if (tails[j]) begin
              r_locked[o] <= 1'b0;
              r_owner[o]  <= '0;
              for (int k = 0; k < IN_PORTS; k++) begin
                if (k != j) begin
                  r_pri[o][j][k] <= 1'b0;
                  r_pri[o][k][j] <= 1'b1;
                end
              end
            end else if (!r_locked[o]) begin
              r_locked[o] <= 1'b1;
              r_owner[o]  <= IN_PORT_BITS'(j);
            end
          end
        end
      end
    end
  end

  always_comb begin
    locked = r_locked;
    owner  = '0;
    for (int o = 0; o < OUT_PORTS; o++)
      owner[o*IN_PORT_BITS +: IN_PORT_BITS] = r_owner[o];
  end

endmodule

// File: tb/tb_arbiter_matrix_locked.sv
// Directed vector bench for arbiter_matrix_locked.
// Expected values are hand-derived from the matrix/lock rules.
module tb_arbiter_matrix_locked;

  typedef struct {
    logic        on;
    logic [4:0]  req;
    logic [14:0] ports;
    logic [4:0]  tails;
    logic [4:0]  rdy;
    logic [4:0]  g;
    logic [4:0]  lk;
    logic [14:0] ow;
    logic [4:0]  err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ON;
  logic [4:0]  requests;
  logic [14:0] req_ports;
  logic [4:0]  tails;
  logic [4:0]  out_ready;
  logic [4:0]  grants;
  logic [4:0]  locked;
  logic [14:0] owner;
  logic [4:0]  port_err;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t vq[$];

  arbiter_matrix_locked dut (
    .clk(clk), .reset(reset), .ON(ON),
    .requests(requests), .req_ports(req_ports),
    .tails(tails), .out_ready(out_ready),
    .grants(grants), .locked(locked),
    .owner(owner), .port_err(port_err)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] rp(int p4, int p3, int p2,
                                     int p1, int p0);
    return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(logic on, logic [4:0] req, logic [14:0] p,
                     logic [4:0] t, logic [4:0] r, logic [4:0] g,
                     logic [4:0] lk, logic [14:0] ow, logic [4:0] e);
    vec_t v;
    v.on = on; v.req = req; v.ports = p; v.tails = t; v.rdy = r;
    v.g = g; v.lk = lk; v.ow = ow; v.err = e;
    vq.push_back(v);
  endtask

  task automatic apply(vec_t v, int idx);
    ON = v.on; requests = v.req; req_ports = v.ports;
    tails = v.tails; out_ready = v.rdy;
    @(negedge clk);
    chk($sformatf("v%0d grants", idx), 32'(grants), 32'(v.g));
    chk($sformatf("v%0d port_err", idx), 32'(port_err), 32'(v.err));
    chk($sformatf("v%0d locked", idx), 32'(locked), 32'(v.lk));
    chk($sformatf("v%0d owner", idx), 32'(owner), 32'(v.ow));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [14:0] o3 = rp(0, 1, 0, 0, 0);
    logic [14:0] o0 = rp(0, 0, 0, 0, 2);
    vec_t h;
    add(1, 5'b00000, 0, 0, 5'h1f, 5'b00000, 0, 0, 0);
    // round-robin of single flits on output 1
    add(1, 5'b10101, rp(1,0,1,0,1), 5'h1f, 5'h1f, 5'b10000, 0, 0, 0);
    add(1, 5'b10101, rp(1,0,1,0,1), 5'h1f, 5'h1f, 5'b00100, 0, 0, 0);
    add(1, 5'b10101, rp(1,0,1,0,1), 5'h1f, 5'h1f, 5'b00001, 0, 0, 0);
    add(1, 5'b10101, rp(1,0,1,0,1), 5'h1f, 5'h1f, 5'b10000, 0, 0, 0);
    // warm-up then wormhole packet on output 3
    add(1, 5'b10000, rp(3,0,0,0,0), 5'h1f, 5'h1f, 5'b10000, 0, 0, 0);
    add(1, 5'b10010, rp(3,0,0,3,0), 0, 5'h1f, 5'b00010, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 5'b10010, rp(3,0,0,3,0), 0, 5'h1f, 5'b00010, 5'b01000, o3, 0);
    add(1, 5'b10000, rp(3,0,0,0,0), 0, 5'h1f, 5'b00000, 5'b01000, o3, 0);
    add(1, 5'b10010, rp(3,0,0,3,0), 5'b00010, 5'h1f, 5'b00010,
        5'b01000, o3, 0);
    add(1, 5'b10010, rp(3,0,0,3,0), 5'b10000, 5'h1f, 5'b10000, 0, 0, 0);
    // back-pressure on output 2
    for (int i = 0; i < 4; i++)
      add(1, 5'b00001, rp(0,0,0,0,2), 0, 5'b11011, 0, 0, 0, 0);
    add(1, 5'b00001, rp(0,0,0,0,2), 0, 5'h1f, 5'b00001, 0, 0, 0);
    add(1, 5'b00001, rp(0,0,0,0,2), 5'h1f, 5'h1f, 5'b00001,
        5'b00100, 0, 0);
    // bad output fields and the last legal one
    add(1, 5'b01000, rp(0,6,0,0,0), 5'h1f, 5'h1f, 0, 0, 0, 5'b01000);
    add(1, 5'b01000, rp(0,5,0,0,0), 5'h1f, 5'h1f, 0, 0, 0, 5'b01000);
    add(1, 5'b01000, rp(0,4,0,0,0), 5'h1f, 5'h1f, 5'b01000, 0, 0, 0);
    // lock output 0 to input 2, then freeze with ON=0
    add(1, 5'b00100, 0, 0, 5'h1f, 5'b00100, 0, 0, 0);
    add(0, 5'b01110, rp(0,6,0,0,0), 0, 5'h1f, 0, 5'b00001, o0, 5'b01000);
    add(0, 5'b01110, rp(0,6,0,0,0), 5'b00100, 5'h1f, 0,
        5'b00001, o0, 5'b01000);
    add(1, 5'b00110, 0, 0, 5'h1f, 5'b00100, 5'b00001, o0, 0);

    reset = 1'b1; ON = 1'b1; requests = 5'b10101;
    req_ports = rp(1,0,1,0,1); tails = 5'h1f; out_ready = 5'h1f;
    #1;
    chk("rst grants", 32'(grants), 0);
    chk("rst locked", 32'(locked), 0);
    chk("rst owner", 32'(owner), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vq[i]) apply(vq[i], i);

    // asynchronous reset with output 0 still locked to input 2
    ON = 1'b1; requests = 5'b00110; req_ports = 0; tails = 0;
    #1 reset = 1'b1;
    #1;
    chk("midrst locked", 32'(locked), 0);
    chk("midrst owner", 32'(owner), 0);
    chk("midrst grants", 32'(grants), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    h = '{1, 5'b10101, rp(1,0,1,0,1), 5'h1f, 5'h1f, 5'b10000, 0, 0, 0};
    apply(h, 100);
    h = '{1, 5'b11000, rp(3,3,0,0,0), 5'h1f, 5'h1f, 5'b10000, 0, 0, 0};
    apply(h, 101);
    // independent tail grants on outputs 0 and 1 in one edge
    h = '{1, 5'b00011, rp(0,0,0,1,0), 5'h1f, 5'h1f, 5'b00011, 0, 0, 0};
    apply(h, 102);
    h = '{1, 5'b00011, rp(0,0,0,1,1), 5'h1f, 5'h1f, 5'b00001, 0, 0, 0};
    apply(h, 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
